// File: rtl/uart_rx_sampler.sv
// UART receive front end: 16x oversampled start-bit detection with glitch
// rejection, mid-bit sampling, optional parity, stop-bit check and a
// valid/ready character output.
module uart_rx_sampler #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_os_tick,
  input  logic                 i_rx_in,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               r_state, w_state_next;
  logic                 r_sync1, r_sync2;
  logic                 w_rxs;
  logic [3:0]           r_tick_cnt, w_tick_cnt_next;
  logic [2:0]           r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par_en, w_par_en_next;
  logic                 r_par_odd, w_par_odd_next;
  logic                 r_par_err_pend, w_par_err_pend_next;
  logic                 w_complete, w_frame_err_next, w_accept;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_parity_err, r_overrun;

  assign w_rxs    = r_sync2;
  assign w_accept = r_rx_valid & i_rx_ready;

  // Two-flop synchronizer for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= StIdle;
      r_tick_cnt     <= 4'd0;
      r_bit_idx      <= 3'd0;
      r_shift        <= '0;
      r_par_en       <= 1'b0;
      r_par_odd      <= 1'b0;
      r_par_err_pend <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_tick_cnt     <= w_tick_cnt_next;
      r_bit_idx      <= w_bit_idx_next;
      r_shift        <= w_shift_next;
      r_par_en       <= w_par_en_next;
      r_par_odd      <= w_par_odd_next;
      r_par_err_pend <= w_par_err_pend_next;
    end
  end

  // Next-state logic; everything advances only on the oversampling strobe.
  always_comb begin
    w_state_next        = r_state;
    w_tick_cnt_next     = r_tick_cnt;
    w_bit_idx_next      = r_bit_idx;
    w_shift_next        = r_shift;
    w_par_en_next       = r_par_en;
    w_par_odd_next      = r_par_odd;
    w_par_err_pend_next = r_par_err_pend;
    w_complete          = 1'b0;
    w_frame_err_next    = 1'b0;
    case (r_state)
      StIdle: begin
        w_tick_cnt_next = 4'd0;
        if (i_os_tick && !w_rxs) w_state_next = StStart;
      end
      StStart: begin
        if (i_os_tick) begin
          if (r_tick_cnt == 4'd7) begin
            w_tick_cnt_next = 4'd0;
            if (w_rxs) begin
              // Line went back high before mid start bit: treat as a glitch.
              w_state_next = StIdle;
            end else begin
              w_state_next        = StData;
              w_bit_idx_next      = 3'd0;
              w_shift_next        = '0;
              w_par_en_next       = i_parity_en;
              w_par_odd_next      = i_parity_odd;
              w_par_err_pend_next = 1'b0;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 4'd1;
          end
        end
      end
      StData: begin
        if (i_os_tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            // Shift in from the top so the first line bit ends up in the LSB.
            w_shift_next   = {w_rxs, r_shift[DATA_BITS-1:1]};
            w_bit_idx_next = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'(DATA_BITS - 1)) begin
              w_state_next = r_par_en ? StParity : StStop;
            end
          end
        end
      end
      StParity: begin
        if (i_os_tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            w_par_err_pend_next = ((^r_shift) ^ w_rxs) != r_par_odd;
            w_state_next        = StStop;
          end
        end
      end
      StStop: begin
        if (i_os_tick) begin
          w_tick_cnt_next = r_tick_cnt + 4'd1;
          if (r_tick_cnt == 4'd15) begin
            // Re-arm at mid stop bit so back-to-back frames are caught.
            w_frame_err_next = ~w_rxs;
            w_complete       = 1'b1;
            w_tick_cnt_next  = 4'd0;
            w_state_next     = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output holding register; a same-edge accept frees the slot for the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete && (!r_rx_valid || w_accept)) begin
        r_rx_data    <= r_shift;
        r_frame_err  <= w_frame_err_next;
        r_parity_err <= r_par_err_pend;
        r_rx_valid   <= 1'b1;
      end else if (w_complete) begin
        r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_data    = r_rx_data;
  assign o_rx_valid   = r_rx_valid;
  assign o_frame_err  = r_frame_err;
  assign o_parity_err = r_parity_err;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: table of frames plus hand-written
// glitch, overrun, same-edge accept, parity-latch and mid-frame reset sequences.
module tb_uart_rx_sampler;

  logic       clk, rst;
  logic       os_tick, rx_in, parity_en, parity_odd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  uart_rx_sampler #(.DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_os_tick   (os_tick),
    .i_rx_in     (rx_in),
    .i_parity_en (parity_en),
    .i_parity_odd(parity_odd),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .i_rx_ready  (rx_ready),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err),
    .o_overrun   (overrun),
    .o_busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ovr_cnt = 0;
  int   tick_no = 0;
  int   start_tick = 0;
  int   frame_no = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk strobe every 4 clk; tick_no names the posedge that sees it.
  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      tick_no++;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare each accepted character against the oldest expectation.
  always begin
    @(negedge clk);
    #2;
    if (overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_char", 32'(rx_data), 32'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int n);
    do @(posedge clk); while (!(os_tick && tick_no == n));
  endtask

  // Start bit launched on the negedge right after a tick, so sample points are known.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop);
    do @(posedge clk); while (!os_tick);
    @(negedge clk);
    start_tick = tick_no;
    frame_no++;
    rx_in = 1'b0;
    hold(64);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      hold(64);
    end
    if (pen) begin
      rx_in = pbit;
      hold(64);
    end
    rx_in = stop;
    hold(64);
    rx_in = 1'b1;
  endtask

  task automatic accept();
    int i;
    for (i = 0; i < 4000 && rx_valid !== 1'b1; i++) @(negedge clk);
    if (rx_valid !== 1'b1) begin
      chk("valid_timeout", 32'(rx_valid), 32'd1);
    end else begin
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_clears", 32'(rx_valid), 32'd0);
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  // Valid must rise (and busy fall) exactly on the stop-sample tick edge.
  task automatic stop_timing(input int fn, input int off);
    int n;
    wait (frame_no == fn + 1);
    n = start_tick + off;
    wait_tick(n - 1);
    hold(4);
    chk("pre_stop_valid", 32'(rx_valid), 32'd0);
    chk("pre_stop_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("post_stop_valid", 32'(rx_valid), 32'd1);
    chk("post_stop_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'd0);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_perr"}, 32'(parity_err), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[9];
    int   fn, k, n;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b0;
    rx_in = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    rx_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    hold(4);
    rst = 1'b1;
    hold(40);

    // Table of frames, each checked for latency and content.
    foreach (vecs[i]) begin
      parity_en = vecs[i].pen;
      parity_odd = vecs[i].podd;
      exp_q.push_back('{vecs[i].data, vecs[i].exp_ferr, vecs[i].exp_perr});
      fn = frame_no;
      fork
        send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
        stop_timing(fn, vecs[i].pen ? 169 : 153);
      join
      accept();
      hold(160);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;

    // Glitch: low for 5 ticks, rejected at the tick-7 sample.
    do @(posedge clk); while (!os_tick);
    @(negedge clk);
    k = tick_no;
    rx_in = 1'b0;
    fork
      begin
        hold(20);
        rx_in = 1'b1;
      end
      begin
        wait_tick(k + 8);
        #1;
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        wait_tick(k + 9);
        #1;
        chk("glitch_busy_lo", 32'(busy), 32'd0);
      end
    join
    hold(200);
    chk("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Parity config changed mid-frame must not affect the frame in flight.
    parity_en = 1'b1;
    parity_odd = 1'b0;
    exp_q.push_back('{8'h03, 1'b0, 1'b0});
    fn = frame_no;
    fork
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      begin
        wait (frame_no == fn + 1);
        hold(200);
        parity_en = 1'b0;
        parity_odd = 1'b1;
      end
    join
    accept();
    parity_en = 1'b0;
    parity_odd = 1'b0;
    hold(160);

    // Overrun: second back-to-back frame is dropped with a one-clk pulse.
    exp_q.push_back('{8'h11, 1'b0, 1'b0});
    fn = frame_no;
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      end
      begin
        wait (frame_no == fn + 2);
        n = start_tick + 153;
        wait_tick(n);
        #1;
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_data_kept", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("ovr_one_clk", 32'(overrun), 32'd0);
      end
    join
    chk("ovr_count", 32'(ovr_cnt), 32'd1);
    accept();
    hold(160);

    // Same-edge completion and acceptance: new data loads, no overrun.
    exp_q.push_back('{8'h11, 1'b0, 1'b0});
    exp_q.push_back('{8'h22, 1'b0, 1'b0});
    fn = frame_no;
    fork
      begin
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      end
      begin
        wait (frame_no == fn + 2);
        n = start_tick + 153;
        wait_tick(n - 1);
        hold(4);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("same_edge_valid", 32'(rx_valid), 32'd1);
        chk("same_edge_data", 32'(rx_data), 32'h22);
        chk("same_edge_no_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    accept();
    chk("same_edge_ovr_count", 32'(ovr_cnt), 32'd1);
    hold(160);

    // Reset mid-frame, with an unaccepted character also pending.
    exp_q.push_back('{8'h42, 1'b0, 1'b0});
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    hold(100);
    do @(posedge clk); while (!os_tick);
    @(negedge clk);
    rx_in = 1'b0;
    hold(64);
    rx_in = 1'b1;
    hold(4 * 64 + 32);
    chk("pre_rst_valid", 32'(rx_valid), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    exp_q.delete();
    hold(3);
    rst = 1'b1;
    hold(400);
    chk("post_rst_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    accept();
    hold(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receive front end that sits directly downstream of the baud generator. It consumes the 16x-oversampling strobe and the asynchronous serial line, and detects start bits with glitch rejection. It samples each bit at mid-bit, checks optional parity and the stop bit, and presents each received character on a valid/ready interface to the host-side logic.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..8.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `os_tick` input 1: one-clk strobe at 16x baud, from the baud generator. Repetition rate is at least every 2 clk.
- `rx_in` input 1: asynchronous serial line; idle high.
- `parity_en` input 1: 1 = frame carries a parity bit after the data bits. Sampled when a start bit is accepted.
- `parity_odd` input 1: 1 = odd parity, 0 = even parity. Sampled when a start bit is accepted.
- `rx_data` output DATA_BITS: received character, LSB = first bit on the line.
- `rx_valid` output 1: character available; held until accepted.
- `rx_ready` input 1: consumer accepts the character when `rx_valid && rx_ready`.
- `frame_err` output 1: stop bit sampled low. Qualified by `rx_valid`.
- `parity_err` output 1: parity mismatch. Qualified by `rx_valid`; always 0 when parity is disabled.
- `overrun` output 1: one-clk pulse when a frame completes while `rx_valid` is still high.
- `busy` output 1: high in every state except IDLE.

## Operation
- **Synchronizer.** `rx_in` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rxs`.
- **Tick counter.** `tick_cnt` is 4 bits and advances only on `os_tick`.
- **IDLE**
  - `tick_cnt` = 0.
  - On `os_tick` with `rxs == 0`, go to START.
- **START**
  - When `tick_cnt` reaches 7 on an `os_tick`, sample `rxs`; this is mid start bit.
  - `rxs == 1`: glitch. Return to IDLE with no outputs changed.
  - `rxs == 0`: latch the parity config, clear `tick_cnt` and the bit index, go to DATA.
- **DATA**
  - On every `os_tick` where `tick_cnt == 15`, sample `rxs` into shift register bit [index] and increment the index. `tick_cnt` wraps to 0.
  - After DATA_BITS samples, go to PARITY if parity is enabled, otherwise go to STOP.
- **PARITY**
  - Sample at `tick_cnt == 15`.
  - Parity error = (XOR of data bits XOR sampled bit) != `parity_odd`.
  - Go to STOP.
- **STOP**
  - Sample at `tick_cnt == 15`, which is mid stop bit. `frame_err_next = ~rxs`.
  - Complete the frame (see below) and return to IDLE on the same edge.
  - Only half the stop bit elapses before re-arming, so back-to-back frames are supported.
- **Frame completion, `rx_valid == 0`:**
  - Load `rx_data` from the shift register. When DATA_BITS < 8, the upper bits of the shift register are 0.
  - Load `frame_err` and `parity_err`.
  - Set `rx_valid`.
- **Frame completion, `rx_valid == 1`:**
  - Pulse `overrun` for one clk.
  - Discard the new frame; `rx_data` and the flags keep the old values.
- **Handshake.**
  - `rx_valid` clears on the clk after `rx_valid && rx_ready`.
  - If completion and acceptance happen on the same edge, acceptance wins: `rx_valid` stays 1, new data is loaded, and there is no overrun.
- **Parity config.** Changes to `parity_en` or `parity_odd` mid-frame do not affect the frame in progress.

## Timing
- **Reset values.**
  - `rx_data` = 0; `rx_valid`, `frame_err`, `parity_err`, `overrun`, `busy` = 0.
  - State = IDLE; `tick_cnt` = 0.
  - Both synchronizer flops = 1.
- **Input latency.** 2 clk from `rx_in` to `rxs`.
- **Sample points.** The start bit is sampled 8 ticks after the falling edge is detected, so the sample lands within 1 tick of mid-bit. Each subsequent bit is sampled exactly 16 ticks after the previous sample.
- **Output latency.** `rx_valid` rises on the clk edge immediately following the `os_tick` cycle of the stop sample: 1 clk after that strobe.
- **Busy.** `busy` rises 1 clk after the `os_tick` that enters START. It falls on the same edge that `rx_valid` rises or `overrun` pulses.
- **Reset mid-frame.** Everything returns to reset values immediately. A partial frame is never reported.

## Test plan
- **Basic 8N1.** `os_tick` every 4 clk, `parity_en` = 0, send 0xA5 (line bits 1,0,1,0,0,1,0,1) -> `rx_data` = 0xA5, `rx_valid` = 1, `frame_err` = 0, `parity_err` = 0; `rx_valid` stays high until `rx_ready` is pulsed, then clears the next clk.
- **Glitch rejection.** `rx_in` low for 5 ticks, then high -> `busy` returns to 0 after the tick-7 sample; `rx_valid` never asserts.
- **Parity.** Even parity, send 0x03 with parity bit 0 -> `parity_err` = 0. Resend 0x03 with parity bit 1 -> `parity_err` = 1. Odd parity, send 0x03 with parity bit 1 -> `parity_err` = 0.
- **Framing error.** Send 0x3C with the stop bit driven 0 -> `rx_data` = 0x3C, `frame_err` = 1.
- **Overrun and back-to-back.** `rx_ready` = 0, send 0x11 then 0x22 back to back -> first `rx_data` = 0x11; a one-clk `overrun` pulse at the second stop sample; `rx_data` still 0x11. Repeat with `rx_ready` asserted exactly on the second completion edge -> `rx_data` = 0x22, no overrun.
- **Reset mid-frame.** Drop `rst` during data bit 4 of 0xFF, then release and send 0x5A -> all outputs 0 during reset; next `rx_data` = 0x5A with no error flags.
